accum_datapath: RTL and testbench
=================================

Name: accum_datapath

Overview:
- Datapath stage directly downstream of the accumulate/save control FSM. It consumes Address, ReadEnable, WriteEnable, Load, Clear, Transfer and Ready.
- Contains the 32-word working memory, a pipelined read path, the operand register, the accumulator, and a saturating write-back path.
- Also has a host port for preloading memory and reading results back.
- Sits between the system host and the FSM's control bus.

Parameters:
DATA_W, 16, memory word and operand width
ADDR_W, 5, memory address width (depth = 2**ADDR_W = 32)
GUARD_W, 3, accumulator guard bits (ACC_W = DATA_W+GUARD_W), sized for 8-term sums

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  synchronous, active-high reset
Address  in  ADDR_W  FSM memory address
ReadEnable  in  1  FSM read request
WriteEnable  in  1  FSM write of saturated accumulator to mem[Address]
Load  in  1  capture memory read data into operand register
Clear  in  1  active-low accumulator clear
Transfer  in  1  accumulate: Acc <= Acc + Operand
Ready  in  1  FSM run-complete pulse
HostWrite  in  1  host write strobe
HostAddr  in  ADDR_W  host address
HostWData  in  DATA_W  host write data
HostRData  out  DATA_W  registered mem[HostAddr], 1-cycle latency
Sum  out  ACC_W  current accumulator value
Overflow  out  1  sticky: a saturated write-back occurred
HostConflict  out  1  one-cycle pulse: host write dropped
Done  out  1  sticky run-complete flag

Behaviour:
- Reset (synchronous, sampled on Clock rise while Reset=1) clears all registers to 0: read pipeline, Operand, Acc, Overflow, HostConflict, Done, HostRData. Memory contents are not reset.
- Read pipeline, 2 stages:
  - Cycle n: ReadEnable=1 registers Address into RdAddrQ.
  - Cycle n+1: RdDataQ <= mem[RdAddrQ].
  - With ReadEnable held for n, n+1, n+2 and Load=1 in n+2, Operand <= RdDataQ = mem[Address at n].
  - With ReadEnable=0, RdAddrQ holds its value.
- Load=1: Operand <= RdDataQ. Otherwise Operand holds.
- Clear=0: Acc <= 0. This has priority over Transfer in the same cycle, and Overflow is also cleared.
- Transfer=1 (with Clear=1): Acc <= Acc + zero-extended Operand, modulo 2**ACC_W. No flag on accumulator wrap.
- WriteEnable=1: mem[Address] <= sat(Acc), where sat = Acc if Acc < 2**DATA_W, else all-ones. A saturated write sets Overflow.
- Write vs read collision: read and write to the same address in one cycle reads the old data (read-before-write).
- Host write:
  - HostWrite=1 and ReadEnable=0 and WriteEnable=0: mem[HostAddr] <= HostWData.
  - If ReadEnable or WriteEnable is high, the host write is dropped and HostConflict=1 on the next cycle. The FSM always has priority.
- HostRData <= mem[HostAddr] every cycle, 1-cycle latency, read-before-write.
- Done:
  - Set on the cycle after Ready=1.
  - Cleared when Clear=0 coincides with Address=0 and ReadEnable=0 (the FSM start state).
  - Ready and the clear condition in the same cycle: set wins.
- Reset mid-run: all registers zero next cycle, and any in-flight read is discarded. A memory write in the same cycle as Reset is suppressed.
- Sum is Acc directly (registered, no extra latency).

Decomposition:
- Shared package accum_pkg holds:
  - DATA_W, ADDR_W, GUARD_W, ACC_W
  - a saturation function sat_to_data
  - the localparam SAT_MAX = all-ones DATA_W
- One natural sub-module: accum_ram, the 32 x DATA_W dual-port RAM.
  - Port A: FSM read/write, registered read.
  - Port B: host read/write.
  - The collision/priority logic stays in the top.

Test Plan:
- Reset: preload mem[0..31]=k+1, assert Reset 2 cycles mid-operation -> Sum=0, Overflow=0, Done=0, HostRData=0 the cycle after release; memory contents unchanged.
- Read latency: ReadEnable=1, Address=5 for 3 cycles, Load in the 3rd -> Operand=mem[5]=6; Load in the 2nd cycle instead -> stale RdDataQ is captured, not 6.
- Accumulate: Clear pulse, then 8 x (read addr k, Load, Transfer) for k=0..7 -> Sum=36. WriteEnable at Address=8 -> mem[8]=36, Overflow=0.
- Saturation: preload 8 words of 0xF000, accumulate -> Sum=0x78000. Write-back -> mem word=0xFFFF, Overflow=1. Next Clear=0 -> Overflow=0, Sum=0.
- Conflict: HostWrite with HostAddr=3, HostWData=0xABCD while ReadEnable=1 -> mem[3] unchanged, HostConflict=1 for exactly one cycle. Repeat with FSM idle -> mem[3]=0xABCD, HostRData=0xABCD one cycle after HostAddr=3.
- Clear/Transfer collision and Done: Clear=0 and Transfer=1 same cycle -> Sum=0. Ready pulse -> Done=1 next cycle and stays 1. Start condition (Clear=0, Address=0, ReadEnable=0) -> Done=0.

Source files
------------

// File: rtl/accum_pkg.sv
// Shared widths, types and saturation helpers
// for the accumulate datapath slice.
package accum_pkg;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 5;
    localparam int GUARD_W = 3;
    localparam int ACC_W   = DATA_W + GUARD_W;
    localparam int DEPTH   = 1 << ADDR_W;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [ACC_W-1:0]  acc_t;

    localparam data_t SAT_MAX = '1;

    // True when the accumulator no longer fits a memory word.
    function automatic logic acc_saturates(input acc_t a);
        return |a[ACC_W-1:DATA_W];
    endfunction

    // Clamp the accumulator to the largest storable word.
    function automatic data_t sat_to_data(input acc_t a);
        if (acc_saturates(a)) begin
            return SAT_MAX;
        end
        return a[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/accum_datapath_if.sv
// Control bus from the FSM plus the host port,
// seen from the driver (master) and the datapath (slave).
interface accum_datapath_if;
    import accum_pkg::*;

    addr_t Address;
    logic  ReadEnable;
    logic  WriteEnable;
    logic  Load;
    logic  Clear;
    logic  Transfer;
    logic  Ready;

    logic  HostWrite;
    addr_t HostAddr;
    data_t HostWData;
    data_t HostRData;

    acc_t  Sum;
    logic  Overflow;
    logic  HostConflict;
    logic  Done;

    modport master (
        output Address, ReadEnable, WriteEnable,
        output Load, Clear, Transfer, Ready,
        output HostWrite, HostAddr, HostWData,
        input  HostRData, Sum, Overflow,
        input  HostConflict, Done
    );

    modport slave (
        input  Address, ReadEnable, WriteEnable,
        input  Load, Clear, Transfer, Ready,
        input  HostWrite, HostAddr, HostWData,
        output HostRData, Sum, Overflow,
        output HostConflict, Done
    );

endinterface

// File: rtl/accum_ram.sv
// 32-word dual-port working memory with registered
// reads on both ports; reads return pre-write data.
import accum_pkg::*;

module accum_ram (
    input  logic  clk,
    input  logic  rst,
    input  addr_t a_raddr,
    input  logic  a_we,
    input  addr_t a_waddr,
    input  data_t a_wdata,
    output data_t a_rdata,
    input  addr_t b_addr,
    input  logic  b_we,
    input  data_t b_wdata,
    output data_t b_rdata
);

    data_t mem [DEPTH];

    data_t a_rdata_d;
    data_t a_rdata_q;
    data_t b_rdata_d;
    data_t b_rdata_q;

    // Read data for both ports; reset flushes them to zero.
    always_comb begin
        a_rdata_d = mem[a_raddr];
        b_rdata_d = mem[b_addr];
        if (rst) begin
            a_rdata_d = '0;
            b_rdata_d = '0;
        end
    end

    // Read registers.
    always_ff @(posedge clk) begin
        a_rdata_q <= a_rdata_d;
        b_rdata_q <= b_rdata_d;
    end

    // Storage writes; the top never enables both ports at once.
    always_ff @(posedge clk) begin
        if (a_we) begin
            mem[a_waddr] <= a_wdata;
        end
        if (b_we) begin
            mem[b_addr] <= b_wdata;
        end
    end

    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;

endmodule

// File: rtl/accum_datapath.sv
// Datapath behind the accumulate/save FSM: read pipe,
// operand, accumulator, saturating write-back, host port.
import accum_pkg::*;

module accum_datapath (
    input  logic              Clock,
    input  logic              Reset,
    accum_datapath_if.slave   bus
);

    addr_t rd_addr_d;
    addr_t rd_addr_q;
    data_t operand_d;
    data_t operand_q;
    acc_t  acc_d;
    acc_t  acc_q;
    logic  overflow_d;
    logic  overflow_q;
    logic  host_conflict_d;
    logic  host_conflict_q;
    logic  done_d;
    logic  done_q;

    data_t rd_data;
    data_t host_rdata;
    data_t wb_data;
    logic  wb_sat;
    logic  fsm_we;
    logic  host_we;
    logic  fsm_busy;
    logic  start_cond;

    // Port-level qualifiers: FSM wins, reset blocks writes.
    always_comb begin
        fsm_busy   = bus.ReadEnable | bus.WriteEnable;
        fsm_we     = bus.WriteEnable & ~Reset;
        host_we    = bus.HostWrite & ~fsm_busy & ~Reset;
        wb_data    = sat_to_data(acc_q);
        wb_sat     = acc_saturates(acc_q);
        start_cond = ~bus.Clear & (bus.Address == '0)
                   & ~bus.ReadEnable;
    end

    // Next-state for every datapath register.
    always_comb begin
        rd_addr_d       = rd_addr_q;
        operand_d       = operand_q;
        acc_d           = acc_q;
        overflow_d      = overflow_q;
        done_d          = done_q;
        host_conflict_d = bus.HostWrite & fsm_busy;

        if (bus.ReadEnable) begin
            rd_addr_d = bus.Address;
        end

        if (bus.Load) begin
            operand_d = rd_data;
        end

        if (!bus.Clear) begin
            acc_d = '0;
        end else if (bus.Transfer) begin
            acc_d = acc_q + {{GUARD_W{1'b0}}, operand_q};
        end

        if (!bus.Clear) begin
            overflow_d = 1'b0;
        end else if (fsm_we && wb_sat) begin
            overflow_d = 1'b1;
        end

        if (bus.Ready) begin
            done_d = 1'b1;
        end else if (start_cond) begin
            done_d = 1'b0;
        end

        if (Reset) begin
            rd_addr_d       = '0;
            operand_d       = '0;
            acc_d           = '0;
            overflow_d      = 1'b0;
            done_d          = 1'b0;
            host_conflict_d = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge Clock) begin
        rd_addr_q       <= rd_addr_d;
        operand_q       <= operand_d;
        acc_q           <= acc_d;
        overflow_q      <= overflow_d;
        done_q          <= done_d;
        host_conflict_q <= host_conflict_d;
    end

    accum_ram u_ram (
        .clk     (Clock),
        .rst     (Reset),
        .a_raddr (rd_addr_q),
        .a_we    (fsm_we),
        .a_waddr (bus.Address),
        .a_wdata (wb_data),
        .a_rdata (rd_data),
        .b_addr  (bus.HostAddr),
        .b_we    (host_we),
        .b_wdata (bus.HostWData),
        .b_rdata (host_rdata)
    );

    assign bus.HostRData    = host_rdata;
    assign bus.Sum          = acc_q;
    assign bus.Overflow     = overflow_q;
    assign bus.HostConflict = host_conflict_q;
    assign bus.Done         = done_q;

endmodule

// File: tb/tb_accum_datapath.sv
// Randomised self-checking bench for accum_datapath
// against a word-level memory/sum model.
module tb_accum_datapath;

    logic clk;
    logic rst;

    accum_datapath_if bus();

    accum_datapath dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_bad;

    logic [15:0] m [32];
    logic        ovf_m;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] sat16(input int unsigned s);
        logic [31:0] v;
        v = s;
        if (v > 32'd65535) return 16'hFFFF;
        return v[15:0];
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic host_wr(input int a, input logic [15:0] d);
        bus.HostWrite = 1'b1;
        bus.HostAddr  = 5'(a);
        bus.HostWData = d;
        cyc();
        bus.HostWrite = 1'b0;
        m[a] = d;
    endtask

    task automatic host_rd(input int a, output logic [15:0] d);
        bus.HostAddr = 5'(a);
        cyc();
        d = bus.HostRData;
    endtask

    task automatic clr(input int a);
        bus.Address = 5'(a);
        bus.Clear   = 1'b0;
        cyc();
        bus.Clear   = 1'b1;
        ovf_m       = 1'b0;
    endtask

    task automatic fetch(input int a);
        bus.Address    = 5'(a);
        bus.ReadEnable = 1'b1;
        cyc();
        cyc();
        bus.Load = 1'b1;
        cyc();
        bus.Load       = 1'b0;
        bus.ReadEnable = 1'b0;
    endtask

    task automatic xfer();
        bus.Transfer = 1'b1;
        cyc();
        bus.Transfer = 1'b0;
    endtask

    task automatic wb(input int a);
        bus.Address     = 5'(a);
        bus.WriteEnable = 1'b1;
        cyc();
        bus.WriteEnable = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0]  rd;
        logic [15:0]  old;
        int unsigned  s;
        int           a;
        int           w;
        logic         hc;

        n_cmp = 0;
        n_bad = 0;
        ovf_m = 1'b0;
        for (int k = 0; k < 32; k++) m[k] = '0;

        rst             = 1'b1;
        bus.Address     = '0;
        bus.ReadEnable  = 1'b0;
        bus.WriteEnable = 1'b0;
        bus.Load        = 1'b0;
        bus.Clear       = 1'b1;
        bus.Transfer    = 1'b0;
        bus.Ready       = 1'b0;
        bus.HostWrite   = 1'b0;
        bus.HostAddr    = '0;
        bus.HostWData   = '0;

        cyc();
        cyc();
        chk("rst_sum", 32'(bus.Sum), 0);
        chk("rst_ovf", 32'(bus.Overflow), 0);
        chk("rst_done", 32'(bus.Done), 0);
        chk("rst_hconf", 32'(bus.HostConflict), 0);
        chk("rst_hrdata", 32'(bus.HostRData), 0);
        rst = 1'b0;

        for (int k = 0; k < 32; k++) host_wr(k, 16'(k + 1));

        // mid-run reset with FSM and host writes pending
        fetch(2);
        xfer();
        chk("pre_sum", 32'(bus.Sum), 32'(m[2]));
        bus.Ready = 1'b1;
        cyc();
        bus.Ready = 1'b0;
        chk("pre_done", 32'(bus.Done), 1);
        rst             = 1'b1;
        bus.Address     = 5'd10;
        bus.ReadEnable  = 1'b1;
        bus.WriteEnable = 1'b1;
        bus.HostWrite   = 1'b1;
        bus.HostAddr    = 5'd11;
        bus.HostWData   = 16'h5555;
        cyc();
        cyc();
        chk("mid_sum", 32'(bus.Sum), 0);
        chk("mid_ovf", 32'(bus.Overflow), 0);
        chk("mid_done", 32'(bus.Done), 0);
        chk("mid_hrdata", 32'(bus.HostRData), 0);
        chk("mid_hconf", 32'(bus.HostConflict), 0);
        rst             = 1'b0;
        bus.ReadEnable  = 1'b0;
        bus.WriteEnable = 1'b0;
        bus.HostWrite   = 1'b0;
        bus.Load        = 1'b1;
        cyc();
        bus.Load = 1'b0;
        xfer();
        chk("flushed_read", 32'(bus.Sum), 0);
        for (int k = 0; k < 32; k++) begin
            host_rd(k, rd);
            chk($sformatf("mem_keep[%0d]", k), 32'(rd), 32'(m[k]));
        end

        // read latency: 3-cycle fetch returns mem[5]
        clr(31);
        fetch(5);
        xfer();
        chk("lat_ok", 32'(bus.Sum), 32'(m[5]));

        // Load one cycle early sees the word left by address 20
        bus.Address    = 5'd20;
        bus.ReadEnable = 1'b1;
        cyc();
        bus.ReadEnable = 1'b0;
        cyc();
        clr(31);
        bus.Address    = 5'd5;
        bus.ReadEnable = 1'b1;
        cyc();
        bus.Load = 1'b1;
        cyc();
        bus.Load       = 1'b0;
        bus.ReadEnable = 1'b0;
        xfer();
        chk("lat_stale", 32'(bus.Sum), 32'(m[20]));

        // 8-term sum of 1..8 and write-back
        clr(31);
        s = 0;
        for (int k = 0; k < 8; k++) begin
            fetch(k);
            xfer();
            s += m[k];
        end
        chk("acc8_sum", 32'(bus.Sum), s);
        wb(8);
        m[8] = sat16(s);
        chk("acc8_ovf", 32'(bus.Overflow), 0);
        host_rd(8, rd);
        chk("acc8_mem", 32'(rd), 36);

        // saturation
        for (int k = 16; k < 24; k++) host_wr(k, 16'hF000);
        clr(31);
        for (int k = 16; k < 24; k++) begin
            fetch(k);
            xfer();
        end
        chk("sat_sum", 32'(bus.Sum), 32'h78000);
        wb(24);
        m[24] = 16'hFFFF;
        chk("sat_ovf", 32'(bus.Overflow), 1);
        host_rd(24, rd);
        chk("sat_mem", 32'(rd), 32'hFFFF);
        clr(31);
        chk("sat_ovf_clr", 32'(bus.Overflow), 0);
        chk("sat_sum_clr", 32'(bus.Sum), 0);

        // host write dropped while FSM reads
        bus.Address    = 5'd0;
        bus.ReadEnable = 1'b1;
        bus.HostWrite  = 1'b1;
        bus.HostAddr   = 5'd3;
        bus.HostWData  = 16'hABCD;
        cyc();
        chk("conf_pulse", 32'(bus.HostConflict), 1);
        bus.ReadEnable = 1'b0;
        bus.HostWrite  = 1'b0;
        cyc();
        chk("conf_one", 32'(bus.HostConflict), 0);
        host_rd(3, rd);
        chk("conf_mem", 32'(rd), 32'(m[3]));
        old = m[3];
        host_wr(3, 16'hABCD);
        chk("host_rbw", 32'(bus.HostRData), 32'(old));
        chk("host_noconf", 32'(bus.HostConflict), 0);
        cyc();
        chk("host_rd", 32'(bus.HostRData), 32'hABCD);

        // host write dropped during FSM write-back (Acc is 0)
        bus.Address     = 5'd30;
        bus.WriteEnable = 1'b1;
        bus.HostWrite   = 1'b1;
        bus.HostAddr    = 5'd31;
        bus.HostWData   = 16'h1234;
        cyc();
        bus.WriteEnable = 1'b0;
        bus.HostWrite   = 1'b0;
        m[30] = 16'h0000;
        chk("conf_we", 32'(bus.HostConflict), 1);
        host_rd(31, rd);
        chk("conf_we_mem", 32'(rd), 32'(m[31]));
        host_rd(30, rd);
        chk("we_mem", 32'(rd), 0);

        // Clear beats Transfer; Done behaviour
        clr(31);
        fetch(4);
        xfer();
        chk("ct_pre", 32'(bus.Sum), 32'(m[4]));
        bus.Address  = 5'd31;
        bus.Clear    = 1'b0;
        bus.Transfer = 1'b1;
        cyc();
        bus.Clear    = 1'b1;
        bus.Transfer = 1'b0;
        chk("ct_sum", 32'(bus.Sum), 0);
        bus.Ready = 1'b1;
        cyc();
        bus.Ready = 1'b0;
        chk("done_set", 32'(bus.Done), 1);
        cyc();
        cyc();
        chk("done_hold", 32'(bus.Done), 1);
        clr(7);
        chk("done_addr7", 32'(bus.Done), 1);
        clr(0);
        chk("done_clr", 32'(bus.Done), 0);
        bus.Address = 5'd0;
        bus.Clear   = 1'b0;
        bus.Ready   = 1'b1;
        cyc();
        bus.Clear = 1'b1;
        bus.Ready = 1'b0;
        chk("done_setwins", 32'(bus.Done), 1);

        // random runs
        for (int r = 0; r < 30; r++) begin
            for (int h = 0; h < $urandom_range(0, 3); h++) begin
                host_wr($urandom_range(0, 31), 16'($urandom));
            end
            clr(31);
            s = 0;
            for (int i = 0; i < $urandom_range(1, 8); i++) begin
                a  = $urandom_range(0, 31);
                hc = ($urandom_range(0, 3) == 0);
                bus.Address    = 5'(a);
                bus.ReadEnable = 1'b1;
                if (hc) begin
                    bus.HostWrite = 1'b1;
                    bus.HostAddr  = 5'($urandom_range(0, 31));
                    bus.HostWData = 16'($urandom);
                end
                cyc();
                bus.HostWrite = 1'b0;
                chk("rnd_hconf", 32'(bus.HostConflict), 32'(hc));
                cyc();
                bus.Load = 1'b1;
                cyc();
                bus.Load       = 1'b0;
                bus.ReadEnable = 1'b0;
                xfer();
                s = (s + m[a]) % (1 << 19);
            end
            chk("rnd_sum", 32'(bus.Sum), s);
            w = $urandom_range(0, 31);
            wb(w);
            m[w] = sat16(s);
            if (s > 65535) ovf_m = 1'b1;
            chk("rnd_ovf", 32'(bus.Overflow), 32'(ovf_m));
            host_rd(w, rd);
            chk("rnd_wb", 32'(rd), 32'(m[w]));
            a = $urandom_range(0, 31);
            host_rd(a, rd);
            chk("rnd_mem", 32'(rd), 32'(m[a]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
